// File: rtl/pwm_ramp_sequencer.sv
// Run-time controller for the three-phase PWM core: core reset/enable sequencing,
// duty target handshake, period-aligned soft start/stop ramps and fault latching.
module pwm_ramp_sequencer #(
    parameter int DW             = 8,
    parameter int STEP           = 1,
    parameter int TICKS_PER_STEP = 4,
    parameter int START_DUTY     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          fault,
    input  logic          fault_clr,
    input  logic [DW-1:0] tgt_duty,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    output logic [DW-1:0] duty_out,
    output logic          pwm_en,
    output logic          pwm_rst,
    output logic          at_target,
    output logic          fault_latched,
    output logic [2:0]    state
);
    // state | meaning
    // IDLE  | core held in reset, targets still accepted
    // ARM   | one cycle: release reset, load START_DUTY, align phase
    // RAMP  | slewing duty toward target at step points
    // RUN   | duty equals target, held
    // STOP  | slewing duty to zero, then back to IDLE
    // FAULT | core forced off until fault_clr with fault low
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_STEP - 1);
    localparam logic [DW:0]   STEP_W     = (DW+1)'(STEP);
    localparam logic [DW-1:0] START_W    = DW'(START_DUTY);

    state_t         st;
    logic [DW-1:0]  target;
    logic [DW-1:0]  phase;
    logic [TW-1:0]  tick;

    logic           accept;
    logic           period_tick;
    logic           step_pt;
    logic [TW-1:0]  tick_next;
    logic [DW-1:0]  ramp_tgt;
    logic [DW:0]    cur_w, tgt_w, gap, mv, sum;
    logic [DW-1:0]  duty_step;
    logic [DW-1:0]  duty_after;

    assign state       = st;
    assign accept      = tgt_valid & tgt_ready;
    assign period_tick = pwm_en & (phase == '1);
    assign step_pt     = period_tick & (tick == TICK_LAST);

    always_comb begin
        ramp_tgt = '0;
        if (st != S_STOP)
            ramp_tgt = accept ? tgt_duty : target;
        cur_w = {1'b0, duty_out};
        tgt_w = {1'b0, ramp_tgt};
        gap   = (tgt_w >= cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);
        mv    = (gap < STEP_W) ? gap : STEP_W;
        sum   = (tgt_w >= cur_w) ? (cur_w + mv) : (cur_w - mv);
        // mv never exceeds the gap, so the carry bit is only a guard
        duty_step  = sum[DW] ? '1 : sum[DW-1:0];
        duty_after = step_pt ? duty_step : duty_out;
        tick_next  = tick;
        if (step_pt)
            tick_next = '0;
        else if (period_tick)
            tick_next = tick + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st            <= S_IDLE;
            duty_out      <= '0;
            target        <= '0;
            phase         <= '0;
            tick          <= '0;
            pwm_en        <= 1'b0;
            pwm_rst       <= 1'b1;
            tgt_ready     <= 1'b1;
            at_target     <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            if (pwm_en)
                phase <= phase + DW'(1);
            if (fault) begin
                st            <= S_FAULT;
                pwm_en        <= 1'b0;
                pwm_rst       <= 1'b1;
                duty_out      <= '0;
                target        <= '0;
                tgt_ready     <= 1'b0;
                at_target     <= 1'b0;
                fault_latched <= 1'b1;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (accept)
                            target <= tgt_duty;
                        if (start && !stop && !fault_latched) begin
                            st       <= S_ARM;
                            pwm_rst  <= 1'b0;
                            duty_out <= START_W;
                            phase    <= '0;
                            tick     <= '0;
                        end
                    end
                    S_ARM: begin
                        pwm_en <= 1'b1;
                        phase  <= '0;
                        if (stop) begin
                            st     <= S_STOP;
                            target <= '0;
                        end else begin
                            st <= S_RAMP;
                            if (accept)
                                target <= tgt_duty;
                        end
                    end
                    S_RAMP: begin
                        if (stop) begin
                            st     <= S_STOP;
                            target <= '0;
                            tick   <= '0;
                        end else begin
                            if (accept)
                                target <= tgt_duty;
                            tick <= tick_next;
                            if (step_pt)
                                duty_out <= duty_step;
                            if (duty_after == ramp_tgt) begin
                                st        <= S_RUN;
                                at_target <= 1'b1;
                                tick      <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            st        <= S_STOP;
                            target    <= '0;
                            tick      <= '0;
                            at_target <= 1'b0;
                        end else if (accept) begin
                            target <= tgt_duty;
                            if (tgt_duty != duty_out) begin
                                st        <= S_RAMP;
                                at_target <= 1'b0;
                                tick      <= '0;
                            end
                        end
                    end
                    S_STOP: begin
                        if (duty_out == '0) begin
                            st      <= S_IDLE;
                            pwm_en  <= 1'b0;
                            pwm_rst <= 1'b1;
                        end else begin
                            tick <= tick_next;
                            if (step_pt) begin
                                duty_out <= duty_step;
                                if (duty_step == '0) begin
                                    st      <= S_IDLE;
                                    pwm_en  <= 1'b0;
                                    pwm_rst <= 1'b1;
                                end
                            end
                        end
                    end
                    S_FAULT: begin
                        if (fault_clr) begin
                            st            <= S_IDLE;
                            fault_latched <= 1'b0;
                            tgt_ready     <= 1'b1;
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: a STEP=1 instance for timing/handshake/fault
// scenarios and a STEP=7, START_DUTY=40 instance for exact landing on targets.
module tb_pwm_ramp_sequencer;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic rst_n, start, stop, fault, fault_clr, tgt_valid;
    logic [DW-1:0] tgt_duty;

    logic a_ready, a_en, a_rst, a_at, a_fl;
    logic [DW-1:0] a_duty;
    logic [2:0] a_state;
    logic b_ready, b_en, b_rst, b_at, b_fl;
    logic [DW-1:0] b_duty;
    logic [2:0] b_state;

    int n_vec = 0;
    int n_err = 0;
    int cycles = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycles++;

    pwm_ramp_sequencer #(.DW(DW), .STEP(1), .TICKS_PER_STEP(2), .START_DUTY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fault(fault),
        .fault_clr(fault_clr), .tgt_duty(tgt_duty), .tgt_valid(tgt_valid),
        .tgt_ready(a_ready), .duty_out(a_duty), .pwm_en(a_en), .pwm_rst(a_rst),
        .at_target(a_at), .fault_latched(a_fl), .state(a_state));

    pwm_ramp_sequencer #(.DW(DW), .STEP(7), .TICKS_PER_STEP(1), .START_DUTY(40)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fault(fault),
        .fault_clr(fault_clr), .tgt_duty(tgt_duty), .tgt_valid(tgt_valid),
        .tgt_ready(b_ready), .duty_out(b_duty), .pwm_en(b_en), .pwm_rst(b_rst),
        .at_target(b_at), .fault_latched(b_fl), .state(b_state));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] v);
        tgt_duty  = v;
        tgt_valid = 1'b1;
        cyc(1);
        tgt_valid = 1'b0;
    endtask

    initial begin
        int t2, bad, mn, last, n;
        logic [DW-1:0] seq[$];
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        tgt_valid = 1'b0; tgt_duty = '0;
        cyc(2);
        chk("rst_state", 32'(a_state), 0);
        chk("rst_duty", 32'(a_duty), 0);
        chk("rst_en", 32'(a_en), 0);
        chk("rst_pwmrst", 32'(a_rst), 1);
        chk("rst_ready", 32'(a_ready), 1);
        chk("rst_at", 32'(a_at), 0);
        chk("rst_fl", 32'(a_fl), 0);
        rst_n = 1'b1;

        // STEP=7 instance: START_DUTY 40 down to 10, up to 63, stop to 0
        send(6'd10);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("b_arm_state", 32'(b_state), 1);
        chk("b_arm_duty", 32'(b_duty), 40);
        cyc(1);
        chk("b_ramp_state", 32'(b_state), 2);
        last = int'(b_duty);
        for (int i = 0; i < 800 && b_state != 3'd3; i++) begin
            cyc(1);
            if (int'(b_duty) != last) begin
                seq.push_back(b_duty);
                last = int'(b_duty);
            end
        end
        chk("b_down_steps", 32'(seq.size()), 5);
        if (seq.size() == 5) begin
            chk("b_down_0", 32'(seq[0]), 33);
            chk("b_down_1", 32'(seq[1]), 26);
            chk("b_down_2", 32'(seq[2]), 19);
            chk("b_down_3", 32'(seq[3]), 12);
            chk("b_down_4", 32'(seq[4]), 10);
        end
        chk("b_run_at", 32'(b_at), 1);
        seq.delete();
        send(6'd63);
        last = int'(b_duty);
        for (int i = 0; i < 1200 && b_state != 3'd3; i++) begin
            cyc(1);
            if (int'(b_duty) != last) begin
                seq.push_back(b_duty);
                last = int'(b_duty);
            end
        end
        chk("b_up_steps", 32'(seq.size()), 8);
        if (seq.size() == 8) begin
            chk("b_up_6", 32'(seq[6]), 59);
            chk("b_up_7", 32'(seq[7]), 63);
        end
        seq.delete();
        stop = 1'b1;
        last = int'(b_duty);
        for (int i = 0; i < 1200 && b_state != 3'd0; i++) begin
            cyc(1);
            if (int'(b_duty) != last) begin
                seq.push_back(b_duty);
                last = int'(b_duty);
            end
        end
        stop = 1'b0;
        chk("b_stop_steps", 32'(seq.size()), 9);
        if (seq.size() == 9)
            chk("b_stop_7", 32'(seq[7]), 7);
        chk("b_stop_duty", 32'(b_duty), 0);
        chk("b_stop_pwmrst", 32'(b_rst), 1);

        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;

        // soft start 0 -> 40, one step per two periods, only on phase wrap
        send(6'd40);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("a_arm_state", 32'(a_state), 1);
        chk("a_arm_pwmrst", 32'(a_rst), 0);
        chk("a_arm_en", 32'(a_en), 0);
        cyc(1);
        chk("a_ramp_state", 32'(a_state), 2);
        chk("a_ramp_en", 32'(a_en), 1);
        t2 = cycles;
        bad = 0;
        last = int'(a_duty);
        for (int i = 0; i < 6000 && a_state != 3'd3; i++) begin
            cyc(1);
            if (int'(a_duty) != last) begin
                if (int'(a_duty) != last + 1 || (cycles - t2) % 128 != 0) bad++;
                last = int'(a_duty);
            end
        end
        chk("a_up_bad", 32'(bad), 0);
        chk("a_up_time", 32'(cycles - t2), 5120);
        chk("a_up_duty", 32'(a_duty), 40);
        chk("a_up_at", 32'(a_at), 1);

        // retarget down to 10 while running
        send(6'd10);
        chk("a_retgt_state", 32'(a_state), 2);
        chk("a_retgt_at", 32'(a_at), 0);
        bad = 0;
        mn = 63;
        last = int'(a_duty);
        for (int i = 0; i < 5000 && a_state != 3'd3; i++) begin
            cyc(1);
            if (int'(a_duty) < mn) mn = int'(a_duty);
            if (int'(a_duty) != last) begin
                if (int'(a_duty) != last - 1 || (cycles - t2) % 64 != 0) bad++;
                last = int'(a_duty);
            end
        end
        chk("a_down_bad", 32'(bad), 0);
        chk("a_down_min", 32'(mn), 10);
        chk("a_down_duty", 32'(a_duty), 10);
        chk("a_down_at", 32'(a_at), 1);

        // soft stop from 60, target sent during STOP is acked but ignored
        send(6'd60);
        for (int i = 0; i < 7000 && a_state != 3'd3; i++) cyc(1);
        chk("a_60_duty", 32'(a_duty), 60);
        stop = 1'b1;
        cyc(1);
        chk("a_stop_state", 32'(a_state), 4);
        chk("a_stop_at", 32'(a_at), 0);
        tgt_duty = 6'd60 + 6'd30;
        tgt_valid = 1'b1;
        chk("a_stop_ready", 32'(a_ready), 1);
        cyc(1);
        tgt_valid = 1'b0;
        bad = 0;
        last = int'(a_duty);
        for (int i = 0; i < 9000 && a_state != 3'd0; i++) begin
            cyc(1);
            if (int'(a_duty) > last) bad++;
            last = int'(a_duty);
        end
        chk("a_stop_bad", 32'(bad), 0);
        chk("a_stop_duty", 32'(a_duty), 0);
        chk("a_stop_en", 32'(a_en), 0);
        chk("a_stop_pwmrst", 32'(a_rst), 1);
        start = 1'b1;
        cyc(3);
        chk("a_startstop", 32'(a_state), 0);
        stop = 1'b0;
        start = 1'b0;

        // fault mid-ramp
        send(6'd30);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 0; i < 1200 && a_duty != 6'd5; i++) cyc(1);
        fault = 1'b1;
        cyc(1);
        fault = 1'b0;
        chk("f_state", 32'(a_state), 5);
        chk("f_en", 32'(a_en), 0);
        chk("f_pwmrst", 32'(a_rst), 1);
        chk("f_duty", 32'(a_duty), 0);
        chk("f_latched", 32'(a_fl), 1);
        chk("f_ready", 32'(a_ready), 0);
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        chk("f_start_ign", 32'(a_state), 5);
        fault = 1'b1;
        fault_clr = 1'b1;
        cyc(1);
        fault = 1'b0;
        chk("f_clr_ign", 32'(a_state), 5);
        cyc(1);
        fault_clr = 1'b0;
        chk("f_clr_state", 32'(a_state), 0);
        chk("f_clr_fl", 32'(a_fl), 0);
        chk("f_clr_ready", 32'(a_ready), 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("f_zero_run", 32'(a_state), 3);
        chk("f_zero_at", 32'(a_at), 1);

        // reset while running at 20
        send(6'd20);
        for (int i = 0; i < 3000 && a_state != 3'd3; i++) cyc(1);
        chk("r_duty", 32'(a_duty), 20);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("r_state", 32'(a_state), 0);
        chk("r_duty0", 32'(a_duty), 0);
        chk("r_en", 32'(a_en), 0);
        chk("r_pwmrst", 32'(a_rst), 1);
        chk("r_at", 32'(a_at), 0);

        // full-scale target held valid: saturates at 63 without wrapping
        tgt_duty = 6'd63;
        tgt_valid = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        bad = 0;
        last = int'(a_duty);
        n = 0;
        for (int i = 0; i < 9000 && a_state != 3'd3; i++) begin
            cyc(1);
            if (int'(a_duty) < last || int'(a_duty) > last + 1) bad++;
            last = int'(a_duty);
        end
        chk("s_bad", 32'(bad), 0);
        chk("s_duty", 32'(a_duty), 63);
        cyc(5);
        chk("s_hold_state", 32'(a_state), 3);
        chk("s_hold_duty", 32'(a_duty), 63);
        chk("s_hold_at", 32'(a_at), 1);
        tgt_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
